// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers
//
// Executes MULT/MULTU/DIV/DIVU over several cycles beside the EX-stage ALU,
// holds the pipeline with stallreq while working, and services MTHI/MTLO.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   op_valid, op    EX instruction valid and its muldiv opcode
//   src1, src2      rs / rt operands
//   ex_hold         later-stage stall keeping the instruction in EX
//   flush           synchronous cancel of the EX instruction
//   stallreq        combinational hold request for IF/ID/EX
//   busy            unit is not idle
//   hi, lo          HI/LO architectural registers
module ex_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_FAST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             stallreq,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   s1_q, s1_d;    // raw operands, kept for signs and div-by-zero
  logic [WIDTH-1:0]   s2_q, s2_d;
  logic [WIDTH-1:0]   opb_q, opb_d;  // |src2|: multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;  // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Decode of the incoming instruction
  logic             in_long, in_signed, in_mul;
  logic [WIDTH-1:0] mag1_in, mag2_in;

  assign in_long   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign mag1_in   = (in_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign mag2_in   = (in_signed && src2[WIDTH-1]) ? -src2 : src2;

  // Decode of the latched instruction
  logic q_signed, q_mul, neg_prod, neg_rem;

  assign q_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign q_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign neg_prod = q_signed && (s1_q[WIDTH-1] ^ s2_q[WIDTH-1]);
  assign neg_rem  = q_signed && s1_q[WIDTH-1];

  // One iteration of the datapath
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] fast_prod, acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    fast_prod = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    if (q_mul) begin
      if (MUL_FAST != 0) acc_step = fast_prod;
      else               acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      // Borrow: trial subtraction failed, keep the shifted remainder
      acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Signed fix-up of the final iteration; MIN/-1 falls out naturally as MIN rem 0
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  always_comb begin
    prod_res = neg_prod ? -acc_step : acc_step;
    quo_res  = neg_prod ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_res  = neg_rem ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    if (!q_mul && (s2_q == {WIDTH{1'b0}})) begin
      quo_res = {WIDTH{1'b1}};
      rem_res = s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid && in_long) begin
            state_d = S_BUSY;
            op_d    = op;
            s1_d    = src1;
            s2_d    = src2;
            opb_d   = mag2_in;
            acc_d   = {{WIDTH{1'b0}}, mag1_in};
            cnt_d   = (MUL_FAST != 0 && in_mul) ? CW'(1) : CW'(WIDTH);
          end else if (op_valid && op == OP_MTHI) begin
            hi_d = src1;
          end else if (op_valid && op == OP_MTLO) begin
            lo_d = src1;
          end
        end
        S_BUSY: begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            if (q_mul) begin
              hi_d = prod_res[2*WIDTH-1:WIDTH];
              lo_d = prod_res[WIDTH-1:0];
            end else begin
              hi_d = rem_res;
              lo_d = quo_res;
            end
          end
        end
        S_DONE: begin
          // Incoming op is ignored here so the finished instruction is never re-issued
          if (!ex_hold) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stallreq = !rst && !flush &&
                    (((state_q == S_IDLE) && op_valid && in_long) || (state_q == S_BUSY));
  assign busy     = (state_q != S_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, ex_hold, flush;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        stallreq, busy;
  logic [31:0] hi, lo;

  logic        f_op_valid;
  logic [2:0]  f_op;
  logic [31:0] f_src1, f_src2;
  logic        f_stallreq, f_busy;
  logic [31:0] f_hi, f_lo;

  int tests_run = 0;
  int failed    = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32), .MUL_FAST(0)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
    .ex_hold(ex_hold), .flush(flush), .stallreq(stallreq), .busy(busy), .hi(hi), .lo(lo)
  );

  ex_muldiv_unit #(.WIDTH(32), .MUL_FAST(1)) dut_fast (
    .clk(clk), .rst(rst), .op_valid(f_op_valid), .op(f_op), .src1(f_src1), .src2(f_src2),
    .ex_hold(1'b0), .flush(1'b0), .stallreq(f_stallreq), .busy(f_busy), .hi(f_hi), .lo(f_lo)
  );

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [31:0] q, rm;
    r = '0;
    case (o)
      OP_MULT:  r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          q  = $signed(a) / $signed(b);
          rm = $signed(a) % $signed(b);
          r  = {rm, q};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drives a long op until the unit reaches DONE; returns at negedge+1 in DONE, inputs still applied
  task automatic run_long(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output bit tmo);
    sb.push_back(model(o, a, b));
    stalls = 0;
    tmo = 1'b1;
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stallreq) stalls++;
      else if (busy) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic leave_ex();
    ex_hold = 1'b0;
    @(negedge clk);
    op_valid = 1'b0; op = 3'b000;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] zero32;
    zero32 = 32'd0;
    op_valid = 1'b1; op = OP_DIV; src1 = 32'd9; src2 = 32'd3;
    #1;
    tests_run++; if (hi !== zero32) begin failed++; $display("FAIL reset_hi got %h exp %h", hi, zero32); end
    tests_run++; if (lo !== zero32) begin failed++; $display("FAIL reset_lo got %h exp %h", lo, zero32); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (stallreq !== 1'b0) begin failed++; $display("FAIL reset_stallreq got %b exp 0", stallreq); end
    tests_run++; if (f_hi !== zero32 || f_busy !== 1'b0) begin failed++; $display("FAIL reset_fast got hi=%h busy=%b exp 0/0", f_hi, f_busy); end
    op_valid = 1'b0; op = 3'b000;
  endtask

  task automatic test_mult();
    logic [2:0]  ops [4];
    logic [31:0] as [4];
    logic [31:0] bs [4];
    logic [63:0] exp;
    int stalls;
    bit tmo;
    ops[0] = OP_MULT;  as[0] = 32'hFFFF_FFFF; bs[0] = 32'h0000_0002;
    ops[1] = OP_MULTU; as[1] = 32'hFFFF_FFFF; bs[1] = 32'h0000_0002;
    ops[2] = OP_MULT;  as[2] = $urandom;      bs[2] = $urandom;
    ops[3] = OP_MULTU; as[3] = $urandom;      bs[3] = $urandom;
    for (int i = 0; i < 4; i++) begin
      run_long(ops[i], as[i], bs[i], stalls, tmo);
      exp = sb.pop_front();
      tests_run++; if (tmo) begin failed++; $display("FAIL mult[%0d] timeout waiting for DONE", i); end
      tests_run++; if (stalls != 33) begin failed++; $display("FAIL mult[%0d] stall_cycles got %0d exp 33", i, stalls); end
      tests_run++; if ({hi, lo} !== exp) begin failed++; $display("FAIL mult[%0d] hilo got %h exp %h", i, {hi, lo}, exp); end
      leave_ex();
      tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL mult[%0d] idle_after got busy=%b exp 0", i, busy); end
    end
  endtask

  task automatic test_divide();
    logic [2:0]  ops [7];
    logic [31:0] as [7];
    logic [31:0] bs [7];
    logic [63:0] exp;
    int stalls;
    bit tmo;
    ops[0] = OP_DIV;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;
    ops[1] = OP_DIVU; as[1] = 32'd100;       bs[1] = 32'd7;
    ops[2] = OP_DIV;  as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF;
    ops[3] = OP_DIVU; as[3] = 32'h1234_5678; bs[3] = 32'd0;
    ops[4] = OP_DIV;  as[4] = 32'hFFFF_FF00; bs[4] = 32'd0;
    ops[5] = OP_DIV;  as[5] = 32'd7;         bs[5] = 32'hFFFF_FFFE;
    ops[6] = OP_DIVU; as[6] = $urandom;      bs[6] = $urandom_range(1, 65535);
    for (int i = 0; i < 7; i++) begin
      run_long(ops[i], as[i], bs[i], stalls, tmo);
      exp = sb.pop_front();
      tests_run++; if (tmo) begin failed++; $display("FAIL div[%0d] timeout waiting for DONE", i); end
      tests_run++; if (stalls + 1 != 34) begin failed++; $display("FAIL div[%0d] ex_residency got %0d exp 34", i, stalls + 1); end
      tests_run++; if (hi !== exp[63:32]) begin failed++; $display("FAIL div[%0d] hi got %h exp %h", i, hi, exp[63:32]); end
      tests_run++; if (lo !== exp[31:0]) begin failed++; $display("FAIL div[%0d] lo got %h exp %h", i, lo, exp[31:0]); end
      leave_ex();
    end
  endtask

  task automatic test_mthi_mtlo();
    op_valid = 1'b1; op = OP_MTHI; src1 = 32'hDEAD_BEEF;
    #1;
    tests_run++; if (stallreq !== 1'b0) begin failed++; $display("FAIL mthi_stall got %b exp 0", stallreq); end
    @(negedge clk);
    #1;
    tests_run++; if (hi !== 32'hDEAD_BEEF) begin failed++; $display("FAIL mthi_hi got %h exp deadbeef", hi); end
    op = OP_MTLO; src1 = 32'h0BAD_F00D;
    #1;
    tests_run++; if (stallreq !== 1'b0) begin failed++; $display("FAIL mtlo_stall got %b exp 0", stallreq); end
    @(negedge clk);
    #1;
    tests_run++; if (lo !== 32'h0BAD_F00D) begin failed++; $display("FAIL mtlo_lo got %h exp 0badf00d", lo); end
    tests_run++; if (hi !== 32'hDEAD_BEEF) begin failed++; $display("FAIL mtlo_hi_kept got %h exp deadbeef", hi); end
    op_valid = 1'b0; op = 3'b000;
  endtask

  task automatic test_flush();
    logic [31:0] ph, pl;
    ph = hi; pl = lo;
    op_valid = 1'b1; op = OP_MTHI; src1 = 32'h5555_5555; flush = 1'b1;
    #1;
    tests_run++; if (stallreq !== 1'b0) begin failed++; $display("FAIL flush_mthi_stall got %b exp 0", stallreq); end
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0; op = 3'b000;
    #1;
    tests_run++; if (hi !== ph) begin failed++; $display("FAIL flush_mthi_hi got %h exp %h", hi, ph); end
    op_valid = 1'b1; op = OP_DIV; src1 = 32'd100; src2 = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b1 || stallreq !== 1'b1) begin failed++; $display("FAIL flush_pre got busy=%b stall=%b exp 1/1", busy, stallreq); end
    flush = 1'b1;
    #1;
    tests_run++; if (stallreq !== 1'b0) begin failed++; $display("FAIL flush_stall got %b exp 0", stallreq); end
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0; op = 3'b000;
    #1;
    tests_run++; if (busy !== 1'b0 || stallreq !== 1'b0) begin failed++; $display("FAIL flush_idle got busy=%b stall=%b exp 0/0", busy, stallreq); end
    tests_run++; if (hi !== ph || lo !== pl) begin failed++; $display("FAIL flush_hilo got %h/%h exp %h/%h", hi, lo, ph, pl); end
    repeat (40) @(negedge clk);
    #1;
    tests_run++; if (hi !== ph || lo !== pl) begin failed++; $display("FAIL flush_hilo_late got %h/%h exp %h/%h", hi, lo, ph, pl); end
  endtask

  task automatic test_hold();
    logic [63:0] exp;
    int stalls;
    bit tmo;
    run_long(OP_MULTU, 32'h0000_FFFF, 32'h0001_0001, stalls, tmo);
    exp = sb.pop_front();
    tests_run++; if (tmo) begin failed++; $display("FAIL hold timeout waiting for DONE"); end
    tests_run++; if ({hi, lo} !== exp) begin failed++; $display("FAIL hold_hilo got %h exp %h", {hi, lo}, exp); end
    ex_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      tests_run++; if (busy !== 1'b1 || stallreq !== 1'b0) begin failed++; $display("FAIL hold[%0d] got busy=%b stall=%b exp 1/0", k, busy, stallreq); end
      tests_run++; if ({hi, lo} !== exp) begin failed++; $display("FAIL hold[%0d] hilo got %h exp %h", k, {hi, lo}, exp); end
    end
    leave_ex();
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b0 || {hi, lo} !== exp) begin failed++; $display("FAIL hold_release got busy=%b hilo=%h exp 0/%h", busy, {hi, lo}, exp); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int stalls;
    bit tmo;
    run_long(OP_DIVU, 32'd100, 32'd7, stalls, tmo);
    exp = sb.pop_front();
    tests_run++; if (tmo || {hi, lo} !== exp) begin failed++; $display("FAIL b2b_first got %h tmo=%b exp %h", {hi, lo}, tmo, exp); end
    @(negedge clk);
    run_long(OP_MULT, 32'hFFFF_FFF9, 32'd3, stalls, tmo);
    exp = sb.pop_front();
    tests_run++; if (tmo || stalls != 33) begin failed++; $display("FAIL b2b_second_stalls got %0d tmo=%b exp 33", stalls, tmo); end
    tests_run++; if ({hi, lo} !== exp) begin failed++; $display("FAIL b2b_second got %h exp %h", {hi, lo}, exp); end
    leave_ex();
  endtask

  task automatic test_fast_mult();
    logic [2:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    int          exp_st [3];
    logic [63:0] exp;
    int stalls;
    bit done;
    ops[0] = OP_MULT;  as[0] = 32'hFFFF_FFFF; bs[0] = 32'd2;   exp_st[0] = 2;
    ops[1] = OP_MULTU; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd2;   exp_st[1] = 2;
    ops[2] = OP_DIVU;  as[2] = 32'd100;       bs[2] = 32'd7;   exp_st[2] = 33;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(ops[i], as[i], bs[i]));
      stalls = 0; done = 1'b0;
      f_op_valid = 1'b1; f_op = ops[i]; f_src1 = as[i]; f_src2 = bs[i];
      for (int c = 0; c < 100 && !done; c++) begin
        #1;
        if (f_stallreq) stalls++;
        else if (f_busy) done = 1'b1;
        if (!done) @(negedge clk);
      end
      exp = sb.pop_front();
      tests_run++; if (!done || stalls != exp_st[i]) begin failed++; $display("FAIL fast[%0d] stalls got %0d done=%b exp %0d", i, stalls, done, exp_st[i]); end
      tests_run++; if ({f_hi, f_lo} !== exp) begin failed++; $display("FAIL fast[%0d] hilo got %h exp %h", i, {f_hi, f_lo}, exp); end
      @(negedge clk);
      f_op_valid = 1'b0; f_op = 3'b000;
    end
  endtask

  task automatic test_async_reset();
    op_valid = 1'b1; op = OP_MTHI; src1 = 32'hA5A5_A5A5;
    @(negedge clk);
    op = OP_MTLO; src1 = 32'h5A5A_5A5A;
    @(negedge clk);
    op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3;
    #1;
    tests_run++; if (hi !== 32'hA5A5_A5A5 || lo !== 32'h5A5A_5A5A) begin failed++; $display("FAIL arst_pre got %h/%h exp a5a5a5a5/5a5a5a5a", hi, lo); end
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++; if (hi !== 32'd0 || lo !== 32'd0) begin failed++; $display("FAIL arst_hilo got %h/%h exp 0/0", hi, lo); end
    tests_run++; if (busy !== 1'b0 || stallreq !== 1'b0) begin failed++; $display("FAIL arst_busy got busy=%b stall=%b exp 0/0", busy, stallreq); end
    op_valid = 1'b0; op = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 3'b000; src1 = '0; src2 = '0; ex_hold = 1'b0; flush = 1'b0;
    f_op_valid = 1'b0; f_op = 3'b000; f_src1 = '0; f_src2 = '0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_mult();
    test_divide();
    test_mthi_mtlo();
    test_flush();
    test_hold();
    test_back_to_back();
    test_fast_mult();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
